// File: rtl/lemmings_pkg.sv
// Shared types for the Lemmings walker and its world model.
// World state enum plus the walker state codes both sides agree on.
package lemmings_pkg;

   typedef enum logic [1:0] {
      SURFACE = 2'd0,
      FALLING = 2'd1,
      BOTTOM  = 2'd2
   } world_state_e;

   localparam logic [2:0] WALK_LEFT  = 3'd0;
   localparam logic [2:0] WALK_RIGHT = 3'd1;
   localparam logic [2:0] FALL_LEFT  = 3'd2;
   localparam logic [2:0] FALL_RIGHT = 3'd3;
   localparam logic [2:0] DIG_LEFT   = 3'd4;
   localparam logic [2:0] DIG_RIGHT  = 3'd5;

endpackage

// File: rtl/lemmings_world.sv
// Environment for the Lemmings walker: 1-D terrain, lemming position and level,
// feeding bump/ground/dig back to the walker each cycle.
module lemmings_world
   import lemmings_pkg::*;
#(
   parameter int               WIDTH      = 16,
   parameter int               START_POS  = 8,
   parameter int               FALL_TICKS = 3,
   parameter int               DIG_TICKS  = 4,
   parameter logic [WIDTH-1:0] INIT_FLOOR = '1,
   localparam int              PW         = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             walk_left,
   input  logic             walk_right,
   input  logic             aaah,
   input  logic             digging,
   input  logic             dig_cmd,
   input  logic             load,
   input  logic [WIDTH-1:0] terrain_in,
   output logic             bump_left,
   output logic             bump_right,
   output logic             ground,
   output logic             dig,
   output logic [PW-1:0]    pos,
   output logic             on_bottom
);

   localparam int FW = $clog2(FALL_TICKS + 1);
   localparam int DW = $clog2(DIG_TICKS + 1);

   world_state_e     state_q, state_d;
   logic [WIDTH-1:0] floor_q;
   logic [FW-1:0]    fall_cnt;
   logic [DW-1:0]    dig_cnt;
   logic [PW-1:0]    pos_step;
   logic             hole_here;
   logic             unused;

   // The walker's scream is observed only; it never changes the world.
   assign unused    = aaah;
   assign hole_here = ~floor_q[pos];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= SURFACE;
      else        state_q <= state_d;
   end

   // Next-state logic; load overrides whatever the world was doing
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         SURFACE: if (hole_here) state_d = FALLING;
         FALLING: if (fall_cnt == FW'(FALL_TICKS - 1)) state_d = BOTTOM;
         BOTTOM:  state_d = BOTTOM;
         default: state_d = SURFACE;
      endcase
      if (load) state_d = SURFACE;
   end

   // Output logic
   always_comb begin
      ground     = 1'b0;
      on_bottom  = (state_q == BOTTOM);
      bump_left  = (pos == '0);
      bump_right = (pos == PW'(WIDTH - 1));
      unique case (state_q)
         SURFACE: ground = floor_q[pos];
         FALLING: ground = 1'b0;
         BOTTOM:  ground = 1'b1;
         default: ground = 1'b0;
      endcase
   end

   // One-cell step; conflicting commands or a wall in the way mean hold
   always_comb begin
      pos_step = pos;
      if (walk_left && !walk_right && pos != '0)
         pos_step = pos - 1'b1;
      else if (walk_right && !walk_left && pos != PW'(WIDTH - 1))
         pos_step = pos + 1'b1;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         floor_q  <= INIT_FLOOR;
         pos      <= PW'(START_POS);
         fall_cnt <= '0;
         dig_cnt  <= '0;
         dig      <= 1'b0;
      end else begin
         dig <= dig_cmd;
         if (load) begin
            floor_q  <= terrain_in;
            pos      <= PW'(START_POS);
            fall_cnt <= '0;
            dig_cnt  <= '0;
         end else begin
            unique case (state_q)
               SURFACE: begin
                  if (hole_here) begin
                     // Falling freezes pos and starts the air-time count
                     fall_cnt <= '0;
                     dig_cnt  <= '0;
                  end else begin
                     pos <= pos_step;
                     if (!digging) begin
                        dig_cnt <= '0;
                     end else if (dig_cnt == DW'(DIG_TICKS - 1)) begin
                        floor_q[pos] <= 1'b0;
                        dig_cnt      <= '0;
                     end else begin
                        dig_cnt <= dig_cnt + 1'b1;
                     end
                  end
               end
               FALLING: begin
                  fall_cnt <= fall_cnt + 1'b1;
                  dig_cnt  <= '0;
               end
               BOTTOM: begin
                  pos     <= pos_step;
                  dig_cnt <= '0;
               end
               default: dig_cnt <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lemmings_world.sv
// Self-checking bench for lemmings_world: directed scenarios plus a random run
// compared against a behavioural world model.
module tb_lemmings_world;

   localparam int W  = 16;
   localparam int SP = 8;
   localparam int FT = 3;
   localparam int DT = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          walk_left = 1'b0, walk_right = 1'b0, aaah = 1'b0, digging = 1'b0;
   logic          dig_cmd = 1'b0, load = 1'b0;
   logic [W-1:0]  terrain_in = '0;
   logic          bump_left, bump_right, ground, dig, on_bottom;
   logic [3:0]    pos;
   logic [8:0]    obs;

   int tests_run = 0;
   int tests_failed = 0;

   // Behavioural world: mode 0 = on top, 1 = in the air, 2 = on the bottom
   logic [W-1:0] m_floor;
   int           m_pos, m_mode, m_air, m_dig_run;
   logic         m_dig;

   lemmings_world dut (
      .clk(clk), .rst_n(rst_n), .walk_left(walk_left), .walk_right(walk_right),
      .aaah(aaah), .digging(digging), .dig_cmd(dig_cmd), .load(load),
      .terrain_in(terrain_in), .bump_left(bump_left), .bump_right(bump_right),
      .ground(ground), .dig(dig), .pos(pos), .on_bottom(on_bottom)
   );

   always #5 clk = ~clk;

   assign obs = {bump_left, bump_right, ground, dig, on_bottom, pos};

   function automatic int moved(input int p, input logic l, input logic r);
      if (l && !r && p > 0) return p - 1;
      if (r && !l && p < W - 1) return p + 1;
      return p;
   endfunction

   function automatic logic [8:0] model_out();
      logic g;
      g = (m_mode == 0) ? m_floor[m_pos] : (m_mode == 2);
      return {m_pos == 0, m_pos == W - 1, g, m_dig, m_mode == 2, 4'(m_pos)};
   endfunction

   task automatic model_reset();
      m_floor = '1; m_pos = SP; m_mode = 0; m_air = 0; m_dig_run = 0; m_dig = 1'b0;
   endtask

   task automatic model_step(input logic wl, input logic wr, input logic dg,
                             input logic dc, input logic ld, input logic [W-1:0] tin);
      m_dig = dc;
      if (ld) begin
         m_floor = tin; m_pos = SP; m_mode = 0; m_air = 0; m_dig_run = 0;
      end else if (m_mode == 0) begin
         if (!m_floor[m_pos]) begin
            m_mode = 1; m_air = 0; m_dig_run = 0;
         end else begin
            if (dg) begin
               m_dig_run++;
               if (m_dig_run == DT) begin
                  m_floor[m_pos] = 1'b0;
                  m_dig_run = 0;
               end
            end else begin
               m_dig_run = 0;
            end
            m_pos = moved(m_pos, wl, wr);
         end
      end else if (m_mode == 1) begin
         m_air++;
         if (m_air == FT) m_mode = 2;
      end else begin
         m_pos = moved(m_pos, wl, wr);
      end
   endtask

   // Drive one cycle of inputs, advance DUT and model together, settle 1 time unit past the edge
   task automatic apply(input logic wl, input logic wr, input logic dg,
                        input logic dc, input logic ld, input logic [W-1:0] tin);
      walk_left = wl; walk_right = wr; digging = dg; dig_cmd = dc; load = ld; terrain_in = tin;
      aaah = ~m_floor[m_pos];
      @(posedge clk);
      model_step(wl, wr, dg, dc, ld, tin);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      walk_left = 0; walk_right = 0; digging = 0; dig_cmd = 0; load = 0; terrain_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++;
      if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8}) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h expected %h", obs, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8});
      end
   endtask

   task automatic test_walk_left();
      for (int i = 1; i <= 8; i++) begin
         apply(1, 0, 0, 0, 0, '0);
         tests_run++;
         if (pos !== 4'(8 - i) || bump_left !== (i == 8)) begin
            tests_failed++;
            $display("FAIL walk_left step %0d: pos %0d bump_left %b expected pos %0d bump_left %b",
                     i, pos, bump_left, 8 - i, i == 8);
         end
      end
      apply(1, 0, 0, 0, 0, '0);
      tests_run++;
      if (pos !== 4'd0 || bump_left !== 1'b1) begin
         tests_failed++;
         $display("FAIL walk_left_wall_hold: pos %0d bump_left %b expected 0 1", pos, bump_left);
      end
   endtask

   task automatic test_hole_fall();
      apply(0, 0, 0, 0, 1, 16'hFDFF);
      apply(0, 1, 0, 0, 0, '0);
      tests_run++;
      if (pos !== 4'd9 || ground !== 1'b0) begin
         tests_failed++;
         $display("FAIL hole_detect: pos %0d ground %b expected 9 0", pos, ground);
      end
      for (int i = 0; i < FT; i++) begin
         apply(0, 1, 0, 0, 0, '0);
         tests_run++;
         if (pos !== 4'd9 || ground !== 1'b0 || on_bottom !== 1'b0) begin
            tests_failed++;
            $display("FAIL falling_cycle %0d: pos %0d ground %b on_bottom %b expected 9 0 0",
                     i, pos, ground, on_bottom);
         end
      end
      apply(0, 1, 0, 0, 0, '0);
      tests_run++;
      if (pos !== 4'd9 || ground !== 1'b1 || on_bottom !== 1'b1) begin
         tests_failed++;
         $display("FAIL landed: pos %0d ground %b on_bottom %b expected 9 1 1", pos, ground, on_bottom);
      end
   endtask

   task automatic test_dig();
      apply(0, 0, 0, 0, 1, '1);
      for (int i = 1; i <= DT; i++) begin
         apply(0, 0, 1, 0, 0, '0);
         tests_run++;
         if (ground !== (i < DT) || pos !== 4'd8) begin
            tests_failed++;
            $display("FAIL dig_cycle %0d: ground %b pos %0d expected %b 8", i, ground, pos, i < DT);
         end
      end
      for (int i = 0; i <= FT; i++) apply(0, 0, 0, 0, 0, '0);
      tests_run++;
      if (on_bottom !== 1'b1 || ground !== 1'b1 || pos !== 4'd8) begin
         tests_failed++;
         $display("FAIL dig_fall_to_bottom: on_bottom %b ground %b pos %0d expected 1 1 8",
                  on_bottom, ground, pos);
      end
   endtask

   task automatic test_dig_interrupt();
      apply(0, 0, 0, 0, 1, '1);
      for (int i = 0; i < 8; i++) begin
         apply(0, 0, (i % 4) != 3, 0, 0, '0);
         tests_run++;
         if (ground !== 1'b1 || on_bottom !== 1'b0) begin
            tests_failed++;
            $display("FAIL dig_interrupt cycle %0d: ground %b on_bottom %b expected 1 0",
                     i, ground, on_bottom);
         end
      end
      apply(0, 0, 0, 0, 0, '0);
      tests_run++;
      if (ground !== 1'b1) begin
         tests_failed++;
         $display("FAIL dig_interrupt_no_hole: ground %b expected 1", ground);
      end
   endtask

   task automatic test_both_and_load();
      for (int i = 0; i < 3; i++) begin
         apply(1, 1, 0, 0, 0, '0);
         tests_run++;
         if (pos !== 4'd8) begin
            tests_failed++;
            $display("FAIL both_walk_hold %0d: pos %0d expected 8", i, pos);
         end
      end
      apply(0, 0, 0, 0, 1, 16'hFEFF);
      apply(0, 1, 0, 0, 0, '0);
      apply(0, 1, 0, 0, 0, '0);
      apply(0, 0, 0, 0, 1, '1);
      tests_run++;
      if (pos !== 4'd8 || ground !== 1'b1 || on_bottom !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_in_fall: pos %0d ground %b on_bottom %b expected 8 1 0",
                  pos, ground, on_bottom);
      end
      apply(0, 1, 0, 0, 0, '0);
      tests_run++;
      if (pos !== 4'd9 || ground !== 1'b1) begin
         tests_failed++;
         $display("FAIL walk_after_load: pos %0d ground %b expected 9 1", pos, ground);
      end
   endtask

   task automatic test_dig_cmd();
      apply(0, 0, 0, 1, 0, '0);
      tests_run++;
      if (dig !== 1'b1) begin
         tests_failed++;
         $display("FAIL dig_cmd_rise: dig %b expected 1", dig);
      end
      apply(0, 0, 0, 0, 0, '0);
      tests_run++;
      if (dig !== 1'b0) begin
         tests_failed++;
         $display("FAIL dig_cmd_fall: dig %b expected 0", dig);
      end
   endtask

   task automatic test_async_reset();
      apply(0, 0, 0, 0, 1, 16'hFEFF);
      apply(0, 1, 0, 0, 0, '0);
      apply(0, 1, 0, 0, 0, '0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      tests_run++;
      if (pos !== 4'd8 || ground !== 1'b1 || on_bottom !== 1'b0 || dig !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset_now: pos %0d ground %b on_bottom %b dig %b expected 8 1 0 0",
                  pos, ground, on_bottom, dig);
      end
      @(negedge clk);
      rst_n = 1'b1;
      apply(0, 0, 0, 0, 0, '0);
      tests_run++;
      if (pos !== 4'd8 || ground !== 1'b1 || on_bottom !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset_resume: pos %0d ground %b on_bottom %b expected 8 1 0",
                  pos, ground, on_bottom);
      end
   endtask

   task automatic test_random();
      logic         wl, wr, dg, dc, ld;
      logic [W-1:0] tin;
      for (int i = 0; i < 600; i++) begin
         ld  = ($urandom_range(0, 24) == 0);
         tin = '1;
         tin[$urandom_range(0, W - 1)] = 1'b0;
         if ($urandom_range(0, 1) == 1) tin[$urandom_range(0, W - 1)] = 1'b0;
         wl  = ($urandom_range(0, 3) == 0);
         wr  = ($urandom_range(0, 2) == 0);
         dg  = ($urandom_range(0, 4) != 0) && ((i / 8) % 3 == 0);
         dc  = $urandom_range(0, 1);
         apply(wl, wr, dg, dc, ld, tin);
         tests_run++;
         if (obs !== model_out()) begin
            tests_failed++;
            $display("FAIL random cycle %0d: got {bl,br,g,dig,bot,pos}=%h expected %h",
                     i, obs, model_out());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_walk_left();
      test_hole_fall();
      test_dig();
      test_dig_interrupt();
      test_both_and_load();
      test_dig_cmd();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
